gpu_blitter: RTL

Parametrised rectangle engine for the graphic system, and the successor to the single-mode GPU draw/clear unit. It sits between the command controller and the framebuffer write port, and fetches pixels from memory through the same read/valid memory interface. Each command is either a COPY (image excerpt to screen) or a FILL (solid rectangle). Additional features:

- signed, clipped destination coordinates
- selectable transparency rule
- optional mirroring
- a valid/ready command handshake
- an abort input

---
 rtl/gpu_blitter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/gpu_blitter.sv
// gpu_blitter -- rectangle engine between the command controller and the
// framebuffer write port. Each accepted command either copies an excerpt of
// a source image (COPY, pixels fetched through mem_*) or fills a solid
// rectangle (FILL). Destination coordinates are signed; pixels outside the
// framebuffer are skipped in one cycle without memory or framebuffer traffic.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready     command handshake (ready only in IDLE)
//   cmd_*                     command fields, captured on acceptance
//   ctrl_abort                drop the running command (no done pulse)
//   busy, done                engine active / one-cycle completion pulse
//   mem_addr, mem_read        source pixel read request
//   mem_data, mem_valid       read response (may be valid in the request cycle)
//   fb_x, fb_y, fb_color,     framebuffer write, combinational, sampled by the
//   fb_write                  framebuffer at the next rising edge
//
// Build option
//   GPU_FLIP_EN  when defined, cmd_flip_x / cmd_flip_y mirror the source
//                excerpt; otherwise they are ignored and no mirror logic exists.
module gpu_blitter #(
   parameter  int FB_WIDTH  = 400,
   parameter  int FB_HEIGHT = 240,
   parameter  int COLOR_W   = 16,
   parameter  int ADDR_W    = 32,
   localparam int XW        = $clog2(FB_WIDTH) + 2,
   localparam int YW        = $clog2(FB_HEIGHT) + 2,
   localparam int FXW       = $clog2(FB_WIDTH) + 1,
   localparam int FYW       = $clog2(FB_HEIGHT) + 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_mode,
   input  logic                cmd_key_en,
   input  logic [COLOR_W-1:0]  cmd_key,
   input  logic                cmd_flip_x,
   input  logic                cmd_flip_y,
   input  logic [ADDR_W-1:0]   cmd_address,
   input  logic [15:0]         cmd_src_x,
   input  logic [15:0]         cmd_src_y,
   input  logic [15:0]         cmd_image_width,
   input  logic [XW-1:0]       cmd_width,
   input  logic [YW-1:0]       cmd_height,
   input  logic signed [XW-1:0] cmd_x,
   input  logic signed [YW-1:0] cmd_y,
   input  logic [COLOR_W-1:0]  cmd_color,
   input  logic                ctrl_abort,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_read,
   input  logic [COLOR_W-1:0]  mem_data,
   input  logic                mem_valid,
   output logic [FXW-1:0]      fb_x,
   output logic [FYW-1:0]      fb_y,
   output logic [COLOR_W-1:0]  fb_color,
   output logic                fb_write
);

   typedef enum logic [1:0] {IDLE, COPY, FILL} state_t;

   localparam logic signed [XW+1:0] FB_W_LIM = (XW+2)'(FB_WIDTH);
   localparam logic signed [YW+1:0] FB_H_LIM = (YW+2)'(FB_HEIGHT);

   state_t state_q, state_d;

   // Command captured at acceptance; the cmd_* inputs are free afterwards.
   logic                 key_en_q;
   logic [COLOR_W-1:0]   key_q;
   logic [ADDR_W-1:0]    address_q;
   logic [15:0]          src_x_q;
   logic [15:0]          src_y_q;
   logic [15:0]          image_width_q;
   logic [XW-1:0]        width_q;
   logic [YW-1:0]        height_q;
   logic signed [XW-1:0] x_q;
   logic signed [YW-1:0] y_q;
   logic [COLOR_W-1:0]   color_q;

   logic [XW-1:0]        pos_x_q;
   logic [YW-1:0]        pos_y_q;
   logic                 done_q;

   logic                 active, accept, zero_cmd, step, finish, last_px;
   logic                 on_screen, transparent;
   logic signed [XW+1:0] dst_x;
   logic signed [YW+1:0] dst_y;
   logic [XW-1:0]        src_col;
   logic [YW-1:0]        src_row;
   logic [ADDR_W-1:0]    rd_addr;

   assign active   = (state_q != IDLE);
   assign accept   = cmd_valid && (state_q == IDLE);
   assign zero_cmd = (cmd_width == '0) || (cmd_height == '0);

   // Two guard bits keep cmd_x + pos_x exact for any operand values.
   assign dst_x = $signed({{2{x_q[XW-1]}}, x_q}) + $signed({2'b00, pos_x_q});
   assign dst_y = $signed({{2{y_q[YW-1]}}, y_q}) + $signed({2'b00, pos_y_q});

   assign on_screen = !dst_x[XW+1] && (dst_x < FB_W_LIM) &&
                      !dst_y[YW+1] && (dst_y < FB_H_LIM);

   assign last_px = (pos_x_q == width_q - XW'(1)) && (pos_y_q == height_q - YW'(1));

`ifdef GPU_FLIP_EN
   logic flip_x_q, flip_y_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flip_x_q <= 1'b0;
         flip_y_q <= 1'b0;
      end else if (accept) begin
         flip_x_q <= cmd_flip_x;
         flip_y_q <= cmd_flip_y;
      end
   end

   assign src_col = flip_x_q ? (width_q - XW'(1) - pos_x_q) : pos_x_q;
   assign src_row = flip_y_q ? (height_q - YW'(1) - pos_y_q) : pos_y_q;
`else
   logic unused_flip;
   assign unused_flip = cmd_flip_x ^ cmd_flip_y;
   assign src_col     = pos_x_q;
   assign src_row     = pos_y_q;
`endif

   // Address wraps modulo 2^ADDR_W; every term is widened before summing.
   assign rd_addr = address_q + ADDR_W'(src_x_q) + ADDR_W'(src_col) +
                    (ADDR_W'(src_y_q) + ADDR_W'(src_row)) * ADDR_W'(image_width_q);

   assign transparent = key_en_q ? (mem_data == key_q) : !mem_data[0];

   // NOTE: state and every registered field use non-blocking assignments so
   // all flops update together from values sampled before the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a signal unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      mem_read  = 1'b0;
      fb_write  = 1'b0;
      step      = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && !zero_cmd) state_d = cmd_mode ? FILL : COPY;
         end
         COPY: begin
            mem_read = on_screen;
            step     = on_screen ? mem_valid : 1'b1;
            fb_write = on_screen && mem_valid && !transparent;
         end
         FILL: begin
            step     = 1'b1;
            fb_write = on_screen;
         end
         default: state_d = IDLE;
      endcase
      if (active && ctrl_abort) begin
         state_d  = IDLE;
         mem_read = 1'b0;
         fb_write = 1'b0;
         step     = 1'b0;
      end
      finish = step && last_px;
      if (finish) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_en_q      <= 1'b0;
         key_q         <= '0;
         address_q     <= '0;
         src_x_q       <= '0;
         src_y_q       <= '0;
         image_width_q <= '0;
         width_q       <= '0;
         height_q      <= '0;
         x_q           <= '0;
         y_q           <= '0;
         color_q       <= '0;
         pos_x_q       <= '0;
         pos_y_q       <= '0;
         done_q        <= 1'b0;
      end else begin
         done_q <= finish || (accept && zero_cmd);
         if (accept) begin
            key_en_q      <= cmd_key_en;
            key_q         <= cmd_key;
            address_q     <= cmd_address;
            src_x_q       <= cmd_src_x;
            src_y_q       <= cmd_src_y;
            image_width_q <= cmd_image_width;
            width_q       <= cmd_width;
            height_q      <= cmd_height;
            x_q           <= cmd_x;
            y_q           <= cmd_y;
            color_q       <= cmd_color;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
         end else if (step) begin
            if (pos_x_q == width_q - XW'(1)) begin
               pos_x_q <= '0;
               pos_y_q <= pos_y_q + YW'(1);
            end else begin
               pos_x_q <= pos_x_q + XW'(1);
            end
         end
      end
   end

   // Outputs are forced to zero when idle so reset and idle look identical.
   assign busy     = active;
   assign done     = done_q;
   assign mem_addr = mem_read ? rd_addr : '0;
   assign fb_x     = fb_write ? dst_x[FXW-1:0] : '0;
   assign fb_y     = fb_write ? dst_y[FYW-1:0] : '0;
   assign fb_color = !fb_write ? '0 : ((state_q == COPY) ? mem_data : color_q);

endmodule
